// File: rtl/mat_vec_loader_pkg.sv
// Shared matrix-engine definitions: default array geometry and the loader
// state encoding, also used by the systolic matrix-vector array.
package mat_vec_loader_pkg;

  localparam int MVE_DIMENSION = 16;
  localparam int MVE_WIDTH     = 8;

  typedef enum logic [1:0] {
    LOAD_V = 2'd0,
    LOAD_M = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/mat_vec_loader.sv
// Serial loader for a matrix-vector job: one vector followed by a row-major
// matrix arrive element by element, then the systolic array is enabled.
module mat_vec_loader
  import mat_vec_loader_pkg::*;
#(
  parameter int DIMENSION  = MVE_DIMENSION,
  parameter int WIDTH      = MVE_WIDTH,
  parameter int RUN_CYCLES = 2*DIMENSION-1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     in_data,
  output logic                                 in_ready,
  output logic [DIMENSION*DIMENSION*WIDTH-1:0] m_rows,
  output logic [DIMENSION*WIDTH-1:0]           v_out,
  output logic                                 en_o,
  output logic                                 busy,
  output logic                                 done,
  output ld_state_e                            state_dbg
);

  localparam int NELEM  = DIMENSION*DIMENSION;
  localparam int ELEM_W = $clog2(NELEM);
  localparam int RUN_W  = $clog2(RUN_CYCLES+1);
  localparam int VIDX_W = $clog2(DIMENSION);

  localparam logic [ELEM_W-1:0] LAST_V   = ELEM_W'(DIMENSION-1);
  localparam logic [ELEM_W-1:0] LAST_M   = ELEM_W'(NELEM-1);
  localparam logic [RUN_W-1:0]  LAST_RUN = RUN_W'(RUN_CYCLES-1);

  ld_state_e           state_q, state_d;
  logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0]    m_q [NELEM];
  logic [WIDTH-1:0]    m_d [NELEM];
  logic [WIDTH-1:0]    v_q [DIMENSION];
  logic [WIDTH-1:0]    v_d [DIMENSION];
  logic                beat;

  // Handshake: a beat is any rising edge with in_valid and in_ready both high;
  // in_ready depends only on state (and reset), never on in_valid.
  assign in_ready  = rst && ((state_q == LOAD_V) || (state_q == LOAD_M));
  assign beat      = in_valid && in_ready;
  assign en_o      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    run_cnt_d  = run_cnt_q;
    m_d        = m_q;
    v_d        = v_q;
    case (state_q)
      LOAD_V: begin
        if (beat) begin
          v_d[elem_cnt_q[VIDX_W-1:0]] = in_data;
          if (elem_cnt_q == LAST_V) begin
            state_d    = LOAD_M;
            elem_cnt_d = '0;
          end else begin
            elem_cnt_d = elem_cnt_q + ELEM_W'(1);
          end
        end
      end
      LOAD_M: begin
        if (beat) begin
          m_d[elem_cnt_q] = in_data;
          if (elem_cnt_q == LAST_M) begin
            state_d    = RUN;
            elem_cnt_d = '0;
            run_cnt_d  = '0;
          end else begin
            elem_cnt_d = elem_cnt_q + ELEM_W'(1);
          end
        end
      end
      RUN: begin
        if (run_cnt_q == LAST_RUN) begin
          state_d   = DONE;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      DONE: begin
        state_d    = LOAD_V;
        elem_cnt_d = '0;
        run_cnt_d  = '0;
      end
      default: state_d = LOAD_V;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LOAD_V;
      elem_cnt_q <= '0;
      run_cnt_q  <= '0;
      m_q        <= '{default: '0};
      v_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      run_cnt_q  <= run_cnt_d;
      m_q        <= m_d;
      v_q        <= v_d;
    end
  end

  // Element k = row*DIMENSION + col, so the flat index is also the row-major slice.
  for (genvar k = 0; k < NELEM; k++) begin : g_m_flat
    assign m_rows[k*WIDTH +: WIDTH] = m_q[k];
  end
  for (genvar i = 0; i < DIMENSION; i++) begin : g_v_flat
    assign v_out[i*WIDTH +: WIDTH] = v_q[i];
  end

endmodule

// File: tb/tb_mat_vec_loader.sv
// Bench for mat_vec_loader: job table with a result scoreboard, element
// probes, and hand-written checks around RUN, DONE and mid-job reset.
module tb_mat_vec_loader;
  import mat_vec_loader_pkg::*;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int NE = D*D;
  localparam int BW = NE*W + D*W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic              in_ready;
  logic [NE*W-1:0]   m_rows;
  logic [D*W-1:0]    v_out;
  logic              en_o;
  logic              busy;
  logic              done;
  ld_state_e         state_dbg;

  mat_vec_loader #(.DIMENSION(D), .WIDTH(W), .RUN_CYCLES(2*D-1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .m_rows(m_rows), .v_out(v_out), .en_o(en_o),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap_pct;
    int v_kind;     // 0: i+1, 1: 8'h80, 2: random
    int m_kind;     // 0: r*16+c, 2: random
    bit ff_in_run;
    bit reset_mid;
  } job_t;

  typedef struct {
    bit         is_m;
    int         r;
    int         c;
    logic [7:0] exp;
  } probe_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           beat_cnt = 0;
  logic [BW-1:0] exp_q[$];
  logic [W-1:0] v_arr [D];
  logic [W-1:0] m_arr [NE];
  job_t         jobs [5];
  probe_t       probes [8];

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int e = 0; e < NE + D; e++) begin
        if (act[e*W +: W] !== exp[e*W +: W]) begin
          if (e < D)
            $display("FAIL %s: v[%0d] got %h required %h", name, e, act[e*W +: W], exp[e*W +: W]);
          else
            $display("FAIL %s: m[%0d][%0d] got %h required %h", name, (e-D)/D, (e-D)%D,
                     act[e*W +: W], exp[e*W +: W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] model_flat();
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < NE; k++) r[D*W + k*W +: W] = m_arr[k];
    for (int i = 0; i < D; i++) r[i*W +: W] = v_arr[i];
    return r;
  endfunction

  // Scoreboard and beat counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (in_valid && in_ready) beat_cnt++;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected: got done=1 required done=0");
      end else begin
        check_wide("job_result", {m_rows, v_out}, exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input int gap_pct);
    int t;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready) begin
      if (t == 200) begin
        n_vec++;
        n_err++;
        $display("FAIL ready_timeout: in_ready 0 for %0d cycles, required 1", t);
        finish_run();
      end
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int b0;
    int dn;
    int en;
    logic [3:0] ef;
    for (int i = 0; i < D; i++)
      v_arr[i] = (j.v_kind == 0) ? W'(i+1) : (j.v_kind == 1) ? 8'h80 : W'($urandom_range(255));
    for (int k = 0; k < NE; k++)
      m_arr[k] = (j.m_kind == 0) ? W'(k) : W'($urandom_range(255));
    if (!j.reset_mid) exp_q.push_back(model_flat());
    b0 = beat_cnt;
    for (int i = 0; i < D; i++) send_beat(v_arr[i], j.gap_pct);
    for (int k = 0; k < NE; k++) send_beat(m_arr[k], j.gap_pct);
    check("beats", 64'(beat_cnt - b0), 64'(NE + D));
    // n counts cycles after the final matrix beat.
    for (int n = 1; n <= 33; n++) begin
      if (j.ff_in_run) begin
        in_valid = (n <= 31);
        in_data  = 8'hFF;
      end
      ef = {n <= 31, n == 32, n <= 32, n == 33};
      check("run_flags{en,done,busy,ready}", 64'({en_o, done, busy, in_ready}), 64'(ef));
      if (j.reset_mid && n == 10) begin
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_flags{en,done,busy,ready}", 64'({en_o, done, busy, in_ready}), 64'(0));
        check_wide("abort_data", {m_rows, v_out}, '0);
        check("abort_state", 64'(state_dbg), 64'(LOAD_V));
        rst = 1'b1;
        dn = 0;
        en = 0;
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          dn += int'(done);
          en += int'(en_o);
        end
        check("abort_no_done", 64'(dn), 64'(0));
        check("abort_no_en", 64'(en), 64'(0));
        return;
      end
      if (n == 33) begin
        check("after_done_state", 64'(state_dbg), 64'(LOAD_V));
        check_wide("retained_data", {m_rows, v_out}, model_flat());
      end
      if (n < 33) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_probes();
    logic [7:0] act;
    for (int p = 0; p < 8; p++) begin
      if (probes[p].is_m) act = m_rows[(probes[p].r*D + probes[p].c)*W +: W];
      else                act = v_out[probes[p].c*W +: W];
      check($sformatf("probe_%s[%0d][%0d]", probes[p].is_m ? "m" : "v", probes[p].r, probes[p].c),
            64'(act), 64'(probes[p].exp));
    end
  endtask

  initial begin
    jobs[0] = '{gap_pct: 0,  v_kind: 0, m_kind: 0, ff_in_run: 1'b0, reset_mid: 1'b0};
    jobs[1] = '{gap_pct: 50, v_kind: 0, m_kind: 0, ff_in_run: 1'b0, reset_mid: 1'b0};
    jobs[2] = '{gap_pct: 0,  v_kind: 1, m_kind: 2, ff_in_run: 1'b1, reset_mid: 1'b0};
    jobs[3] = '{gap_pct: 20, v_kind: 2, m_kind: 2, ff_in_run: 1'b0, reset_mid: 1'b1};
    jobs[4] = '{gap_pct: 0,  v_kind: 0, m_kind: 0, ff_in_run: 1'b0, reset_mid: 1'b0};

    probes[0] = '{is_m: 1'b1, r: 3,  c: 5,  exp: 8'h35};
    probes[1] = '{is_m: 1'b1, r: 0,  c: 0,  exp: 8'h00};
    probes[2] = '{is_m: 1'b1, r: 15, c: 15, exp: 8'hFF};
    probes[3] = '{is_m: 1'b1, r: 15, c: 0,  exp: 8'hF0};
    probes[4] = '{is_m: 1'b1, r: 7,  c: 9,  exp: 8'h79};
    probes[5] = '{is_m: 1'b0, r: 0,  c: 0,  exp: 8'h01};
    probes[6] = '{is_m: 1'b0, r: 0,  c: 15, exp: 8'h10};
    probes[7] = '{is_m: 1'b0, r: 0,  c: 9,  exp: 8'h0A};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags{en,done,busy,ready}", 64'({en_o, done, busy, in_ready}), 64'(0));
    check_wide("reset_data", {m_rows, v_out}, '0);
    check("reset_state", 64'(state_dbg), 64'(LOAD_V));
    rst = 1'b1;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'(1));

    for (int j = 0; j < 5; j++) begin
      run_job(jobs[j]);
      if (j <= 1 || j == 4) run_probes();
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    finish_run();
  end

  initial begin
    #1000000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    finish_run();
  end

endmodule

// File: doc/mat_vec_loader.md
MAT_VEC_LOADER -- requirements
Module: mat_vec_loader

Interface
REQ-001 SHALL have parameter DIMENSION, default 16, meaning the number of elements per row and per vector.
REQ-002 SHALL have parameter WIDTH, default 8, meaning the bits per element.
REQ-003 SHALL have parameter RUN_CYCLES, default 2*DIMENSION-1, meaning how many cycles en_o is held high per job.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: one signed element of the serial stream.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts an element this cycle.
REQ-009 SHALL have port m_rows, output, DIMENSION*DIMENSION*WIDTH bits: the packed matrix.
- Row r occupies slice [(r+1)*DIMENSION*WIDTH-1 : r*DIMENSION*WIDTH].
- Column c within a row occupies [(c+1)*WIDTH-1 : c*WIDTH].
REQ-010 SHALL have port v_out, output, DIMENSION*WIDTH bits: the packed vector; element i occupies [(i+1)*WIDTH-1 : i*WIDTH].
REQ-011 SHALL have port en_o, output, 1 bit: enable for the downstream systolic matrix-vector array.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at job end.

Function
REQ-014 SHALL implement states LOAD_V, LOAD_M, RUN, DONE in a single registered FSM.
REQ-015 SHALL define an element transfer as the rising edge at which in_valid=1 and in_ready=1 (a beat).
REQ-016 SHALL drive in_ready=1 exactly when rst=1 and state is LOAD_V or LOAD_M; in_ready SHALL be combinational from state only, never from in_valid.
REQ-017 SHALL, in LOAD_V, write beat k (k=0..DIMENSION-1) into v_out element k.
REQ-018 SHALL move from LOAD_V to LOAD_M on beat DIMENSION-1 and clear the element counter.
REQ-019 SHALL, in LOAD_M, write beat k (k=0..DIMENSION*DIMENSION-1) into row k/DIMENSION, column k%DIMENSION (row-major order).
REQ-020 SHALL move from LOAD_M to RUN on beat DIMENSION*DIMENSION-1.
REQ-021 SHALL assert en_o from the first RUN cycle, so en_o is high on the cycle after the final matrix beat.
REQ-022 SHALL hold en_o high for exactly RUN_CYCLES consecutive cycles, then enter DONE.
REQ-023 SHALL keep m_rows and v_out stable throughout RUN and DONE; writes SHALL occur only on beats.
REQ-024 SHALL set done=1 for exactly one cycle in DONE, with en_o=0, then return to LOAD_V.
REQ-025 SHALL retain m_rows and v_out on return to LOAD_V until they are overwritten by new beats.
REQ-026 SHALL hold state and counter unchanged in LOAD states when in_valid=0; gaps of any length are legal.
REQ-027 SHALL ignore in_valid and in_data while in RUN and DONE.
REQ-028 SHALL size the element counter $clog2(DIMENSION*DIMENSION) bits and the run counter $clog2(RUN_CYCLES+1) bits; neither counter SHALL wrap except by its explicit clear.
REQ-029 SHALL make the transition out of any state depend only on the current state, the counters and the beat.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, force state=LOAD_V, both counters=0, m_rows=0, v_out=0, en_o=0, done=0; busy=0 and in_ready=0 follow.
REQ-031 SHALL abort any job if reset is applied mid-job: no done pulse, en_o low on the next cycle, and the partially loaded data cleared.

Structure
REQ-032 SHALL take DIMENSION, WIDTH and the state encoding from the shared matrix-engine package, which the matrix-vector array also uses.
REQ-033 SHALL be a single module with no sub-modules; the buffer SHALL be a register array flattened onto m_rows.

Verification
REQ-034 SHALL cover a back-to-back load, D=16, W=8: v[i]=i+1 and M[r][c]=r*16+c (8-bit truncated) with no gaps.
- m_rows row 3 column 5 = 8'h35.
- en_o high exactly cycles 1..31 after the final beat; done exactly at cycle 32.
REQ-035 SHALL cover random in_valid gaps at a 50% rate: loaded data identical to REQ-034, and total beats accepted = 272.
REQ-036 SHALL cover in_valid=1 held with data 8'hFF during RUN: no buffer change, in_ready=0, busy=1.
REQ-037 SHALL cover reset asserted at run cycle 10: the next cycle has en_o=0, m_rows=0, state LOAD_V, and no done pulse.
REQ-038 SHALL cover two consecutive jobs, the second with v[i]=8'h80: the first done is followed by in_ready=1 on the next cycle, and the second job's outputs match its own data.
